// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port, 1-cycle-latency memory between
// instruction fetch and load/store; load/store wins by default, a wait counter bounds fetch starvation.
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  input  logic              if_kill_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [XLEN/8-1:0] dm_be_i,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [XLEN-1:0]   dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } respTag_t;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  respTag_t   respQ, respD;
  logic [3:0] waitCnt, waitCntD;
  logic       dmWeQ;
  logic       ifGnt, dmGnt;

  // Byte-offset bits never reach the word-addressed memory.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  always_comb begin
    ifGnt = 1'b0;
    dmGnt = 1'b0;
    if (if_req_i && (!dm_req_i || (waitCnt == MaxWait))) begin
      ifGnt = 1'b1;
    end else if (dm_req_i) begin
      dmGnt = 1'b1;
    end
  end

  assign if_gnt_o = ifGnt;
  assign dm_gnt_o = dmGnt;

  always_comb begin
    respD    = RESP_NONE;
    waitCntD = waitCnt;
    if (ifGnt) begin
      respD    = RESP_IF;
      waitCntD = 4'd0;
    end else if (dmGnt) begin
      respD = RESP_DM;
    end
    if (if_req_i && !ifGnt && (waitCnt < MaxWait)) begin
      waitCntD = waitCnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      respQ   <= RESP_NONE;
      waitCnt <= 4'd0;
      dmWeQ   <= 1'b0;
    end else begin
      respQ   <= respD;
      waitCnt <= waitCntD;
      if (dmGnt) begin
        dmWeQ <= dm_we_i;
      end
    end
  end

  always_comb begin
    mem_req_o   = ifGnt | dmGnt;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ifGnt) begin
      mem_addr_o = {if_addr_i[XLEN-1:2], 2'b00};
    end else if (dmGnt) begin
      mem_we_o    = dm_we_i;
      mem_be_o    = dm_be_i;
      mem_addr_o  = {dm_addr_i[XLEN-1:2], 2'b00};
      mem_wdata_o = dm_wdata_i;
    end
  end

  // Qualifying with rstn_i drops a response already tagged when reset is asserted.
  assign if_rvalid_o = (respQ == RESP_IF) && !if_kill_i && rstn_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rvalid_o = (respQ == RESP_DM) && rstn_i;
  assign dm_rdata_o  = (dm_rvalid_o && !dmWeQ) ? mem_rdata_i : '0;

endmodule
